tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 0, meaning extra idle clk_50m cycles inserted between the transmitter going idle and the next grant (range 0-255).
REQ-002 SHALL have port clk_50m, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 4, per-requester byte-send request, level, held until ack.
REQ-005 SHALL have port req_data, input, 32, byte of requester i on bits [8i+7:8i], stable while req[i] is high.
REQ-006 SHALL have port ack, output, 4, one-cycle pulse: the byte of requester i has been captured.
REQ-007 SHALL have port tx_din, output, 8, byte presented to the UART transmitter.
REQ-008 SHALL have port tx_wr_en, output, 1, one-cycle write strobe to the transmitter.
REQ-009 SHALL have port tx_busy, input, 1, transmitter busy (high from the cycle after wr_en until the stop bit completes).
REQ-010 SHALL have port owner, output, 2, index of the most recently granted requester.
REQ-011 SHALL have port arb_busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, GRANT, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-013 IDLE: when any req bit is high and tx_busy is low, select the winner, latch its byte into tx_din, set owner and go to GRANT; otherwise stay.
REQ-014 GRANT (1 cycle): ack[winner] is high for exactly this cycle; next state is ISSUE.
REQ-015 ISSUE (1 cycle): tx_wr_en is high for exactly this cycle; tx_din is unchanged; next state is WAIT_BUSY.
REQ-016 WAIT_BUSY: on tx_busy high go to WAIT_DONE; if tx_busy stays low for 4 cycles, return to ISSUE (re-strobe, same byte).
REQ-017 WAIT_DONE: on tx_busy low go to GAP if IDLE_GAP>0, else to IDLE.
REQ-018 GAP: an 8-bit counter counts IDLE_GAP cycles, then the block returns to IDLE.
REQ-019 Latency: req seen in IDLE at edge k gives ack in cycle k+1 and tx_wr_en in cycle k+2.
REQ-020 Default arbitration is round-robin: search starts at owner+1 modulo 4; the pointer updates only on a grant.
REQ-021 req bits are sampled only in IDLE; a req that drops before grant is forgotten; requests arriving in other states wait.
REQ-022 A requester may hold req through ack to send its next byte; round-robin still gives other pending requesters priority.
REQ-023 At most one ack bit is high in any cycle; ack and tx_wr_en are never high in the same cycle.
REQ-024 tx_busy high while in IDLE blocks the grant until it falls.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, ack=0, tx_wr_en=0, tx_din=8'h00, owner=2'd3 (so requester 0 wins first), arb_busy=0, gap counter=0.
REQ-026 A reset during any state SHALL abandon the pending byte with no ack reissue; the first grant after reset follows REQ-013.

Configuration
REQ-027 With macro TX_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (req[0] highest, req[3] lowest) and owner is only reported; undefined, round-robin per REQ-020 applies.

Verification
REQ-028 Single request: req=4'b0010, req_data[15:8]=8'hA5 -> ack=4'b0010 one cycle, then tx_wr_en one cycle with tx_din=8'hA5, owner=1.
REQ-029 All four req held continuously with round-robin after reset -> grants in order 0,1,2,3,0; each tx_wr_en only after the prior tx_busy fall.
REQ-030 Same stimulus with TX_ARB_FIXED_PRIO_EN defined -> requester 0 granted on every byte.
REQ-031 Lost strobe: tx_busy held low after tx_wr_en -> tx_wr_en reissued exactly 5 cycles after the first, same tx_din, no second ack.
REQ-032 IDLE_GAP=3: next grant ack occurs 3 cycles after tx_busy falls plus the WAIT_DONE->GAP and GAP->IDLE transitions (ack in the 6th cycle after the fall).
REQ-033 rst_n pulsed low during WAIT_DONE -> outputs at reset values within the same cycle; the next request goes to requester 0 first.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter: four-way byte arbiter in front of a single UART transmitter.
// A winner is picked from the pending requests, its byte is latched and
// acknowledged, then strobed into the transmitter. If the transmitter does
// not go busy, the same byte is strobed again. An optional idle gap can be
// inserted after each byte.
//
// Build option: define TX_ARB_FIXED_PRIO_EN for fixed priority (req[0]
// highest). Without it, arbitration is round-robin starting after owner.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for any req while the transmitter is idle
// GRANT     | ack pulse to the winner, byte already latched in tx_din
// ISSUE     | tx_wr_en pulse
// WAIT_BUSY | waiting for tx_busy; after 4 quiet cycles the byte is re-strobed
// WAIT_DONE | transmitter busy, waiting for it to finish
// GAP       | IDLE_GAP idle cycles before the next grant

module tx_arbiter #(
  parameter int IDLE_GAP = 0
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  tx_din,
  output logic        tx_wr_en,
  input  logic        tx_busy,
  output logic [1:0]  owner,
  output logic        arb_busy
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t     state;
  logic [1:0] wait_cnt;
  logic [7:0] gap_cnt;
  logic [1:0] winner;
  logic [1:0] idx;

  // Winner selection from the live request vector.
  always_comb begin
    winner = owner;
    idx    = owner;
`ifdef TX_ARB_FIXED_PRIO_EN
    // Scan from lowest priority upward so req[0] is written last and wins.
    for (int i = 3; i >= 0; i--) begin
      idx = 2'(i);
      if (req[idx]) winner = idx;
    end
`else
    // Scan from farthest to nearest so owner+1 is written last and wins.
    for (int k = 4; k >= 1; k--) begin
      idx = owner + 2'(k);
      if (req[idx]) winner = idx;
    end
`endif
  end

  // Arbiter state machine with registered outputs.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ack      <= 4'b0000;
      tx_wr_en <= 1'b0;
      tx_din   <= 8'h00;
      owner    <= 2'd3;
      arb_busy <= 1'b0;
      wait_cnt <= 2'd0;
      gap_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if ((|req) && !tx_busy) begin
            state    <= GRANT;
            tx_din   <= req_data[{winner, 3'b000} +: 8];
            owner    <= winner;
            ack      <= 4'b0001 << winner;
            arb_busy <= 1'b1;
          end
        end
        GRANT: begin
          ack      <= 4'b0000;
          tx_wr_en <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          tx_wr_en <= 1'b0;
          wait_cnt <= 2'd3;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == 2'd0) begin
            // Strobe was lost: resend the same byte without a new ack.
            tx_wr_en <= 1'b1;
            state    <= ISSUE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (IDLE_GAP > 0) begin
              gap_cnt <= 8'(IDLE_GAP - 1);
              state   <= GAP;
            end else begin
              arb_busy <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            arb_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          ack      <= 4'b0000;
          tx_wr_en <= 1'b0;
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: one instance with no idle gap, one with
// IDLE_GAP=3, each driving a small behavioural transmitter model.
module tb_tx_arbiter;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic [3:0]  req, ack;
  logic [31:0] req_data;
  logic [7:0]  tx_din;
  logic        tx_wr_en, tx_busy, arb_busy;
  logic [1:0]  owner;

  logic [3:0]  req_g, ack_g;
  logic [31:0] req_data_g;
  logic [7:0]  tx_din_g;
  logic        tx_wr_en_g, tx_busy_g, arb_busy_g;
  logic [1:0]  owner_g;

  logic drop = 1'b0, force_busy = 1'b0;
  int   busy_cnt, busy_cnt_g;
  int   total = 0, bad = 0;

  always #10 clk_50m = ~clk_50m;

  tx_arbiter #(.IDLE_GAP(0)) u_dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .tx_din(tx_din), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
    .owner(owner), .arb_busy(arb_busy));

  tx_arbiter #(.IDLE_GAP(3)) u_gap (
    .clk_50m(clk_50m), .rst_n(rst_n), .req(req_g), .req_data(req_data_g),
    .ack(ack_g), .tx_din(tx_din_g), .tx_wr_en(tx_wr_en_g), .tx_busy(tx_busy_g),
    .owner(owner_g), .arb_busy(arb_busy_g));

  // Transmitter models: busy for 3 cycles starting the cycle after a strobe.
  always @(posedge clk_50m or negedge rst_n)
    if (!rst_n) busy_cnt <= 0;
    else if (tx_wr_en && !drop) busy_cnt <= 3;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  assign tx_busy = (busy_cnt != 0) || force_busy;

  always @(posedge clk_50m or negedge rst_n)
    if (!rst_n) busy_cnt_g <= 0;
    else if (tx_wr_en_g) busy_cnt_g <= 3;
    else if (busy_cnt_g > 0) busy_cnt_g <= busy_cnt_g - 1;
  assign tx_busy_g = (busy_cnt_g != 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk_50m);
      n++;
    end while (ack == 4'b0000 && n < 60);
    chk("ack_timeout", 32'(ack != 4'b0000), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk_50m);
      n++;
    end while (arb_busy && n < 60);
    chk("idle_timeout", 32'(arb_busy), 0);
  endtask

  // Exclusivity of ack and strobe on both instances.
  always @(negedge clk_50m)
    if (rst_n) begin
      chk("overlap", 32'((|ack) & tx_wr_en), 0);
      chk("ack_1hot", 32'($onehot0(ack)), 1);
      chk("overlap_g", 32'((|ack_g) & tx_wr_en_g), 0);
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e;
    req = 4'b0; req_data = 32'h0; req_g = 4'b0; req_data_g = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_50m);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_wr", 32'(tx_wr_en), 0);
    chk("rst_din", 32'(tx_din), 0);
    chk("rst_owner", 32'(owner), 3);
    chk("rst_abusy", 32'(arb_busy), 0);
    rst_n = 1'b1;
    @(negedge clk_50m);

    // Single request from requester 1.
    req = 4'b0010; req_data = 32'h0000_A500;
    @(negedge clk_50m);
    chk("s_ack", 32'(ack), 32'h2);
    chk("s_owner", 32'(owner), 1);
    chk("s_abusy", 32'(arb_busy), 1);
    chk("s_wr_early", 32'(tx_wr_en), 0);
    req = 4'b0;
    @(negedge clk_50m);
    chk("s_ack_off", 32'(ack), 0);
    chk("s_wr", 32'(tx_wr_en), 1);
    chk("s_din", 32'(tx_din), 32'hA5);
    @(negedge clk_50m);
    chk("s_wr_pulse", 32'(tx_wr_en), 0);
    wait_idle();

    // All four held after reset.
    rst_n = 1'b0;
    @(negedge clk_50m);
    rst_n = 1'b1;
    req = 4'hF; req_data = 32'h4332_2110;
    for (int g = 0; g < 5; g++) begin
`ifdef TX_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = g % 4;
`endif
      wait_ack();
      chk("rr_ack", 32'(ack), 32'(1 << e));
      chk("rr_owner", 32'(owner), 32'(e));
      @(negedge clk_50m);
      chk("rr_wr", 32'(tx_wr_en), 1);
      chk("rr_din", 32'(tx_din), 32'(8'h10 + 8'(e * 8'h11)));
      chk("rr_prev_done", 32'(tx_busy), 0);
    end
    req = 4'b0;
    wait_idle();

    // Lost strobe: transmitter ignores the first write.
    drop = 1'b1;
    req = 4'b0100; req_data = 32'h00C3_0000;
    wait_ack();
    chk("ls_ack", 32'(ack), 32'h4);
    req = 4'b0;
    @(negedge clk_50m);
    chk("ls_wr1", 32'(tx_wr_en), 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_50m);
      chk("ls_wr", 32'(tx_wr_en), 32'(i == 5));
      chk("ls_no_ack", 32'(ack), 0);
      if (i == 5) begin
        chk("ls_din", 32'(tx_din), 32'hC3);
        drop = 1'b0;
      end
    end
    wait_idle();

    // Busy transmitter blocks a grant from IDLE.
    force_busy = 1'b1;
    req = 4'b0001; req_data = 32'h0000_005A;
    repeat (3) begin
      @(negedge clk_50m);
      chk("bb_ack", 32'(ack), 0);
      chk("bb_abusy", 32'(arb_busy), 0);
    end
    force_busy = 1'b0;
    @(negedge clk_50m);
    chk("bb_grant", 32'(ack), 32'h1);
    req = 4'b0;
    wait_idle();

    // Reset while in WAIT_DONE, then requester 0 must win first.
    req = 4'b0010; req_data = 32'h0000_7700;
    wait_ack();
    req = 4'b0;
    n = 0;
    do begin
      @(negedge clk_50m);
      n++;
    end while (!tx_busy && n < 20);
    @(negedge clk_50m);
    chk("wd_owner", 32'(owner), 1);
    chk("wd_abusy", 32'(arb_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ack", 32'(ack), 0);
    chk("ar_wr", 32'(tx_wr_en), 0);
    chk("ar_din", 32'(tx_din), 0);
    chk("ar_owner", 32'(owner), 3);
    chk("ar_abusy", 32'(arb_busy), 0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    req = 4'hF; req_data = 32'h4433_2211;
    wait_ack();
    chk("ar_first", 32'(ack), 32'h1);
    req = 4'b0;
    wait_idle();

    // IDLE_GAP=3 instance: second grant lands in the 6th cycle of the fall.
    req_g = 4'b0001; req_data_g = 32'h0000_00EE;
    n = 0;
    do begin @(negedge clk_50m); n++; end while (!tx_busy_g && n < 30);
    n = 0;
    do begin @(negedge clk_50m); n++; end while (tx_busy_g && n < 30);
    n = 1;
    while (ack_g == 4'b0000 && n < 20) begin
      @(negedge clk_50m);
      n++;
    end
    chk("gap_lat", 32'(n), 6);
    chk("gap_ack", 32'(ack_g), 32'h1);
    chk("gap_din", 32'(tx_din_g), 32'hEE);
    req_g = 4'b0;
    repeat (20) @(negedge clk_50m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
